// File: rtl/prio_arbiter_if.sv
// Request/grant bundle between a set of requesters and prio_arbiter.
interface prio_arbiter_if #(
  parameter int N  = 8,
  parameter int CW = 16,
  parameter int W  = $clog2(N)
);
  logic [N-1:0]  req;
  logic          mode;
  logic          ack;
  logic          gnt_valid;
  logic [W-1:0]  gnt_idx;
  logic [N-1:0]  gnt_onehot;
  logic          busy;
  logic [CW-1:0] gnt_cnt;

  modport master (
    output req, mode, ack,
    input  gnt_valid, gnt_idx, gnt_onehot, busy, gnt_cnt
  );

  modport slave (
    input  req, mode, ack,
    output gnt_valid, gnt_idx, gnt_onehot, busy, gnt_cnt
  );
endinterface

// File: rtl/prio_arbiter.sv
// Two-state arbiter: fixed (MSB-first) or round-robin winner, grant held until ack.
// Includes a small invariant checker bound to the registered outputs.
module prio_arbiter_chk #(
  parameter int N = 8,
  parameter int W = 3
) (
  input logic         clk,
  input logic         rst,
  input logic         valid,
  input logic [W-1:0] idx,
  input logic [N-1:0] onehot,
  input logic         busy
);
  localparam logic [N-1:0] OH_ONE  = N'(1);
  localparam logic [N-1:0] OH_ZERO = N'(0);

  a_onehot_matches_idx: assert property (@(posedge clk) disable iff (rst)
    valid |-> (onehot == (OH_ONE << idx)));

  a_onehot_zero_when_idle: assert property (@(posedge clk) disable iff (rst)
    !valid |-> (onehot == OH_ZERO));

  a_busy_tracks_valid: assert property (@(posedge clk) disable iff (rst)
    busy == valid);
endmodule

module prio_arbiter #(
  parameter int N  = 8,
  parameter int CW = 16
) (
  input logic           clk,
  input logic           rst,
  prio_arbiter_if.slave bus
);
  localparam int W = $clog2(N);

  localparam logic [W-1:0]  IDX_ZERO = W'(0);
  localparam logic [W-1:0]  IDX_ONE  = W'(1);
  localparam logic [W-1:0]  IDX_LAST = W'(N - 1);
  localparam logic [N-1:0]  OH_ZERO  = N'(0);
  localparam logic [N-1:0]  OH_ONE   = N'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t        state_r, state_s;
  logic          valid_r, valid_s;
  logic [W-1:0]  idx_r, idx_s;
  logic [N-1:0]  onehot_r, onehot_s;
  logic          busy_r, busy_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [W-1:0]  ptr_r, ptr_s;
  logic [W-1:0]  win_s;

  function automatic logic [W-1:0] fixed_winner(input logic [N-1:0] r);
    logic [W-1:0] w;
    w = IDX_ZERO;
    for (int i = 0; i < N; i++) begin
      w = r[i] ? W'(i) : w;
    end
    return w;
  endfunction

  // Scan ptr, ptr+1, ..., wrapping at N; the first set bit wins.
  function automatic logic [W-1:0] rr_winner(input logic [N-1:0] r,
                                             input logic [W-1:0] p);
    logic [W-1:0] w;
    logic         found;
    int           k;
    w     = IDX_ZERO;
    found = 1'b0;
    for (int off = 0; off < N; off++) begin
      k     = int'(p) + off;
      k     = (k >= N) ? (k - N) : k;
      w     = (!found && r[k]) ? W'(k) : w;
      found = found | r[k];
    end
    return w;
  endfunction

  // Winner for the current request vector under the current mode
  always_comb begin
    win_s = IDX_ZERO;
    if (bus.mode) begin
      win_s = rr_winner(bus.req, ptr_r);
    end else begin
      win_s = fixed_winner(bus.req);
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_s  = state_r;
    valid_s  = valid_r;
    idx_s    = idx_r;
    onehot_s = onehot_r;
    busy_s   = busy_r;
    cnt_s    = cnt_r;
    ptr_s    = ptr_r;
    case (state_r)
      ST_IDLE: begin
        if (|bus.req) begin
          state_s  = ST_GRANT;
          valid_s  = 1'b1;
          busy_s   = 1'b1;
          idx_s    = win_s;
          onehot_s = OH_ONE << win_s;
        end else begin
          valid_s  = 1'b0;
          busy_s   = 1'b0;
          onehot_s = OH_ZERO;
        end
      end
      ST_GRANT: begin
        // The grant is frozen until ack; req and mode are ignored here.
        if (bus.ack) begin
          state_s  = ST_IDLE;
          valid_s  = 1'b0;
          busy_s   = 1'b0;
          onehot_s = OH_ZERO;
          cnt_s    = cnt_r + CNT_ONE;
          ptr_s    = (idx_r == IDX_LAST) ? IDX_ZERO : (idx_r + IDX_ONE);
        end else begin
          state_s  = ST_GRANT;
          valid_s  = valid_r;
          busy_s   = busy_r;
          onehot_s = onehot_r;
        end
      end
      default: begin
        state_s  = ST_IDLE;
        valid_s  = 1'b0;
        busy_s   = 1'b0;
        onehot_s = OH_ZERO;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      valid_r  <= 1'b0;
      idx_r    <= IDX_ZERO;
      onehot_r <= OH_ZERO;
      busy_r   <= 1'b0;
      cnt_r    <= CNT_ZERO;
      ptr_r    <= IDX_ZERO;
    end else begin
      state_r  <= state_s;
      valid_r  <= valid_s;
      idx_r    <= idx_s;
      onehot_r <= onehot_s;
      busy_r   <= busy_s;
      cnt_r    <= cnt_s;
      ptr_r    <= ptr_s;
    end
  end

  assign bus.gnt_valid  = valid_r;
  assign bus.gnt_idx    = idx_r;
  assign bus.gnt_onehot = onehot_r;
  assign bus.busy       = busy_r;
  assign bus.gnt_cnt    = cnt_r;

  prio_arbiter_chk #(.N(N), .W(W)) u_chk (
    .clk    (clk),
    .rst    (rst),
    .valid  (valid_r),
    .idx    (idx_r),
    .onehot (onehot_r),
    .busy   (busy_r)
  );
endmodule

// File: tb/tb_prio_arbiter.sv
// Bench for prio_arbiter: table of {inputs, expected outputs} plus hand-written
// corner sequences; expectations go through a scoreboard queue.
module tb_prio_arbiter;
  logic clk;
  logic rst;

  prio_arbiter_if #(.N(8), .CW(16)) b8 ();
  prio_arbiter_if #(.N(5), .CW(4))  b5 ();

  prio_arbiter #(.N(8), .CW(16)) dut (.clk(clk), .rst(rst), .bus(b8.slave));
  prio_arbiter #(.N(5), .CW(4))  dut5 (.clk(clk), .rst(rst), .bus(b5.slave));

  typedef struct {
    logic [7:0]  req;
    logic        mode;
    logic        ack;
    logic        ev;
    logic [4:0]  eidx;
    logic [15:0] ecnt;
  } vec_t;

  typedef struct {
    logic        ev;
    logic [4:0]  eidx;
    logic [31:0] eoh;
    logic        ebusy;
    logic [15:0] ecnt;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[24];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic v, input logic [4:0] ix, input logic [15:0] c);
    exp_t e;
    e.ev    = v;
    e.eidx  = ix;
    e.eoh   = v ? (32'd1 << ix) : 32'd0;
    e.ebusy = v;
    e.ecnt  = c;
    sb.push_back(e);
  endtask

  task automatic sample(input int sel, input string nm);
    exp_t        e;
    logic        v;
    logic [4:0]  ix;
    logic [31:0] oh;
    logic        b;
    logic [15:0] c;
    if (sel == 0) begin
      v = b8.gnt_valid; ix = {2'b00, b8.gnt_idx}; oh = {24'h0, b8.gnt_onehot};
      b = b8.busy;      c  = b8.gnt_cnt;
    end else begin
      v = b5.gnt_valid; ix = {2'b00, b5.gnt_idx}; oh = {27'h0, b5.gnt_onehot};
      b = b5.busy;      c  = {12'h0, b5.gnt_cnt};
    end
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty", nm);
    end else begin
      e = sb.pop_front();
      cmp({nm, ".gnt_valid"},  32'(v),  32'(e.ev));
      cmp({nm, ".gnt_idx"},    32'(ix), 32'(e.eidx));
      cmp({nm, ".gnt_onehot"}, oh,      e.eoh);
      cmp({nm, ".busy"},       32'(b),  32'(e.ebusy));
      cmp({nm, ".gnt_cnt"},    32'(c),  32'(e.ecnt));
    end
  endtask

  task automatic step(input int sel, input string nm, input logic [7:0] r, input logic m,
                      input logic a, input logic v, input logic [4:0] ix, input logic [15:0] c);
    if (sel == 0) begin
      b8.req = r; b8.mode = m; b8.ack = a;
    end else begin
      b5.req = r[4:0]; b5.mode = m; b5.ack = a;
    end
    push_exp(v, ix, c);
    @(posedge clk);
    #1;
    sample(sel, nm);
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic do_reset(input string nm);
    rst = 1'b1;
    #2;
    push_exp(1'b0, 5'd0, 16'd0);
    sample(0, nm);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    b8.req = 8'h00; b8.mode = 1'b0; b8.ack = 1'b0;
    b5.req = 5'h00; b5.mode = 1'b0; b5.ack = 1'b0;

    tbl[0]  = '{8'h00, 1'b0, 1'b0, 1'b0, 5'd0, 16'd0};
    tbl[1]  = '{8'h26, 1'b0, 1'b0, 1'b1, 5'd5, 16'd0};
    tbl[2]  = '{8'h26, 1'b0, 1'b0, 1'b1, 5'd5, 16'd0};
    tbl[3]  = '{8'h00, 1'b0, 1'b1, 1'b0, 5'd5, 16'd1};
    tbl[4]  = '{8'h00, 1'b0, 1'b1, 1'b0, 5'd5, 16'd1};
    tbl[5]  = '{8'h40, 1'b1, 1'b0, 1'b1, 5'd6, 16'd1};
    tbl[6]  = '{8'h40, 1'b1, 1'b1, 1'b0, 5'd6, 16'd2};
    tbl[7]  = '{8'h05, 1'b1, 1'b0, 1'b1, 5'd0, 16'd2};
    tbl[8]  = '{8'h05, 1'b1, 1'b1, 1'b0, 5'd0, 16'd3};
    tbl[9]  = '{8'h05, 1'b1, 1'b0, 1'b1, 5'd2, 16'd3};
    tbl[10] = '{8'h05, 1'b1, 1'b1, 1'b0, 5'd2, 16'd4};
    tbl[11] = '{8'h08, 1'b0, 1'b0, 1'b1, 5'd3, 16'd4};
    tbl[12] = '{8'h00, 1'b1, 1'b0, 1'b1, 5'd3, 16'd4};
    tbl[13] = '{8'h00, 1'b0, 1'b0, 1'b1, 5'd3, 16'd4};
    tbl[14] = '{8'h00, 1'b1, 1'b0, 1'b1, 5'd3, 16'd4};
    tbl[15] = '{8'h00, 1'b0, 1'b0, 1'b1, 5'd3, 16'd4};
    tbl[16] = '{8'h00, 1'b1, 1'b0, 1'b1, 5'd3, 16'd4};
    tbl[17] = '{8'h00, 1'b0, 1'b1, 1'b0, 5'd3, 16'd5};
    tbl[18] = '{8'hFF, 1'b1, 1'b1, 1'b1, 5'd4, 16'd5};
    tbl[19] = '{8'hFF, 1'b1, 1'b1, 1'b0, 5'd4, 16'd6};
    tbl[20] = '{8'hFF, 1'b1, 1'b0, 1'b1, 5'd5, 16'd6};
    tbl[21] = '{8'hFF, 1'b0, 1'b1, 1'b0, 5'd5, 16'd7};
    tbl[22] = '{8'hFF, 1'b0, 1'b0, 1'b1, 5'd7, 16'd7};
    tbl[23] = '{8'hFF, 1'b1, 1'b1, 1'b0, 5'd7, 16'd8};

    do_reset("reset0");

    for (int i = 0; i < 24; i++) begin
      step(0, $sformatf("tbl%0d", i), tbl[i].req, tbl[i].mode, tbl[i].ack,
           tbl[i].ev, tbl[i].eidx, tbl[i].ecnt);
    end

    // Round-robin fairness with all requesters active and ack always high.
    do_reset("reset1");
    for (int c = 0; c < 18; c++) begin
      step(0, $sformatf("rr%0d", c), 8'hFF, 1'b1, 1'b1,
           (c % 2) == 0, 5'((c / 2) % 8), 16'((c + 1) / 2));
    end

    // Asynchronous reset while a grant is held; no handshake is counted.
    do_reset("reset2");
    step(0, "mid_grant0", 8'h08, 1'b1, 1'b0, 1'b1, 5'd3, 16'd0);
    step(0, "mid_grant1", 8'h08, 1'b1, 1'b0, 1'b1, 5'd3, 16'd0);
    #1;
    rst = 1'b1;
    #1;
    push_exp(1'b0, 5'd0, 16'd0);
    sample(0, "async_rst");
    #1;
    rst = 1'b0;
    step(0, "post_rst_idle", 8'h00, 1'b1, 1'b0, 1'b0, 5'd0, 16'd0);
    step(0, "post_rst_ptr0", 8'h0C, 1'b1, 1'b0, 1'b1, 5'd2, 16'd0);
    step(0, "post_rst_ack",  8'h0C, 1'b1, 1'b1, 1'b0, 5'd2, 16'd1);

    // N=5, CW=4 instance: pointer wraps at a non power of two, counter wraps.
    b8.req = 8'h00; b8.ack = 1'b0;
    do_reset("reset3");
    for (int c = 0; c < 32; c++) begin
      step(1, $sformatf("wrap%0d", c), 8'h1F, 1'b1, 1'b1,
           (c % 2) == 0, 5'((c / 2) % 5), 16'(((c + 1) / 2) % 16));
    end
    for (int c = 0; c < 3; c++) begin
      step(1, $sformatf("idle_ack%0d", c), 8'h00, 1'b1, 1'b1, 1'b0, 5'd0, 16'd0);
    end

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
